// File: rtl/exe_unit_mc_if.sv
// Interface between the ID/EX register and the execute stage.
// The master drives the instruction and its operands. The slave returns the EX/MEM outputs.
interface exe_unit_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             stall_in;
    logic             flush;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic [WIDTH-1:0] imme;
    logic [WIDTH-1:0] pc_src;
    logic [3:0]       alu_op;
    logic [1:0]       control_b;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       fwd_w;
    logic [WIDTH-1:0] alu_back;
    logic [WIDTH-1:0] wb_data;
    logic             branch_en;
    logic [1:0]       jorb;
    logic             out_valid;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] new_pc;
    logic             pc_taken;
    logic             busy;

    modport master (
        output in_valid, stall_in, flush, rdata1, rdata2, imme, pc_src, alu_op,
               control_b, fwd_a, fwd_b, fwd_w, alu_back, wb_data, branch_en, jorb,
        input  out_valid, alu_res, wdata, new_pc, pc_taken, busy
    );

    modport slave (
        input  in_valid, stall_in, flush, rdata1, rdata2, imme, pc_src, alu_op,
               control_b, fwd_a, fwd_b, fwd_w, alu_back, wb_data, branch_en, jorb,
        output out_valid, alu_res, wdata, new_pc, pc_taken, busy
    );
endinterface

// File: rtl/exe_unit_mc.sv
// Registered execute stage containing forwarding muxes, the ALU and branch resolution.
// An iterative multiply/divide unit runs one bit per cycle and stalls upstream while it runs.
module exe_unit_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic          clk,
    input logic          rst,
    exe_unit_mc_if.slave io
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NEG  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_SNE  = 4'hA;
    localparam logic [3:0] OP_PC   = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_DIVU = 4'hD;
    localparam logic [3:0] OP_REMU = 4'hE;

    logic [1:0]       state;
    logic [3:0]       it_op;
    logic [WIDTH-1:0] it_a;    // multiplicand, or the quotient shifting in over the dividend
    logic [WIDTH-1:0] it_b;    // multiplier or divisor
    logic [WIDTH-1:0] it_acc;  // product or partial remainder
    logic [WIDTH-1:0] it_wd;
    logic [WIDTH-1:0] it_pc;
    logic [SHW-1:0]   cnt;

    logic             busy;
    logic             accept;
    logic             is_iter;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] b_val;
    logic [WIDTH-1:0] st_val;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] br_pc;
    logic             br_taken;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] it_result;

    function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] native,
                                                 input logic [WIDTH-1:0] ex_val,
                                                 input logic [WIDTH-1:0] wb_val);
        case (sel)
            2'b00:   return native;
            2'b01:   return ex_val;
            2'b10:   return wb_val;
            default: return '0;
        endcase
    endfunction

    assign busy    = (state != S_IDLE);
    assign io.busy = busy;
    assign accept  = io.in_valid & ~busy & ~io.stall_in & ~io.flush;
    assign is_iter = (io.alu_op == OP_MUL) | (io.alu_op == OP_DIVU) | (io.alu_op == OP_REMU);

    // Forwarding selects the register value first. control_b then chooses between that value and the immediate.
    assign a_val  = fwd_sel(io.fwd_a, io.rdata1, io.alu_back, io.wb_data);
    assign b_reg  = fwd_sel(io.fwd_b, io.rdata2, io.alu_back, io.wb_data);
    assign st_val = fwd_sel(io.fwd_w, io.rdata2, io.alu_back, io.wb_data);
    assign b_val  = (io.control_b == 2'b00) ? b_reg :
                    (io.control_b == 2'b01) ? io.imme : '0;
    assign sh     = b_val[SHW-1:0];

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        alu_out = '0;
        case (io.alu_op)
            OP_ADD: alu_out = a_val + b_val;
            OP_SUB: alu_out = a_val - b_val;
            OP_AND: alu_out = a_val & b_val;
            OP_OR:  alu_out = a_val | b_val;
            OP_NEG: alu_out = '0 - a_val;
            OP_NOT: alu_out = ~a_val;
            OP_SLL: alu_out = a_val << sh;
            OP_SRL: alu_out = a_val >> sh;
            OP_SRA: alu_out = $unsigned($signed(a_val) >>> sh);
            OP_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(a_val) < $signed(b_val))};
            OP_SNE: alu_out = {{(WIDTH-1){1'b0}}, (a_val != b_val)};
            OP_PC:  alu_out = io.pc_src;
            default: alu_out = '0;
        endcase
    end

    assign target = io.pc_src + io.imme;

    always_comb begin
        br_taken = 1'b0;
        br_pc    = io.pc_src;
        if (io.branch_en) begin
            case (io.jorb)
                2'b00: begin br_taken = 1'b1;               br_pc = target; end
                2'b01: begin br_taken = 1'b1;               br_pc = a_val;  end
                2'b10: begin br_taken = (a_val == '0);      br_pc = br_taken ? target : io.pc_src; end
                default: begin br_taken = (a_val != '0);    br_pc = br_taken ? target : io.pc_src; end
            endcase
        end
    end

    // Restoring division step. A zero divisor always passes the compare, which yields an all-ones quotient and remainder = A.
    assign rem_sh   = {it_acc, it_a[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, it_b});
    assign rem_diff = rem_sh - {1'b0, it_b};

    assign it_result = (it_op == OP_DIVU) ? it_a : it_acc;

    // NOTE: all sequential state uses non-blocking assignments, so every register samples its pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            it_op  <= OP_ADD;
            it_a   <= '0;
            it_b   <= '0;
            it_acc <= '0;
            it_wd  <= '0;
            it_pc  <= '0;
            cnt    <= '0;
        end else if (io.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_iter) begin
                        state  <= S_RUN;
                        it_op  <= io.alu_op;
                        it_a   <= a_val;
                        it_b   <= b_val;
                        it_acc <= '0;
                        it_wd  <= st_val;
                        it_pc  <= io.pc_src;
                        cnt    <= SHW'(WIDTH - 1);
                    end
                end
                S_RUN: begin
                    if (it_op == OP_MUL) begin
                        if (it_b[0]) it_acc <= it_acc + it_a;
                        it_a <= it_a << 1;
                        it_b <= it_b >> 1;
                    end else begin
                        it_acc <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                        it_a   <= {it_a[WIDTH-2:0], rem_ge};
                    end
                    cnt <= cnt - SHW'(1);
                    if (cnt == '0) state <= S_DONE;
                end
                S_DONE: begin
                    if (!io.stall_in) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // EX/MEM output register. flush wins over everything else, and stall_in freezes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io.out_valid <= 1'b0;
            io.pc_taken  <= 1'b0;
            io.alu_res   <= '0;
            io.wdata     <= '0;
            io.new_pc    <= '0;
        end else if (io.flush) begin
            io.out_valid <= 1'b0;
            io.pc_taken  <= 1'b0;
        end else if (!io.stall_in) begin
            if (state == S_DONE) begin
                io.out_valid <= 1'b1;
                io.pc_taken  <= 1'b0;
                io.alu_res   <= it_result;
                io.wdata     <= it_wd;
                io.new_pc    <= it_pc;
            end else if (accept && !is_iter) begin
                io.out_valid <= 1'b1;
                io.pc_taken  <= br_taken;
                io.alu_res   <= alu_out;
                io.wdata     <= st_val;
                io.new_pc    <= br_pc;
            end else begin
                io.out_valid <= 1'b0;
                io.pc_taken  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exe_unit_mc.sv
// Directed testbench for exe_unit_mc. Expected results are queued when an instruction is issued.
// Each queued result is popped and compared when out_valid rises.
module tb_exe_unit_mc;

    logic clk;
    logic rst;

    exe_unit_mc_if #(.WIDTH(16)) bus ();

    exe_unit_mc #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic [15:0] wd;
        logic [15:0] npc;
        logic        tk;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic saw_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 ns later. Any valid output must match the oldest queued expectation.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        saw_out = bus.out_valid;
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 16'(sb.size()), 16'd1);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_res"}, bus.alu_res, e.res);
                chk({e.tag, "_wdata"}, bus.wdata, e.wd);
                chk({e.tag, "_new_pc"}, bus.new_pc, e.npc);
                chk({e.tag, "_pc_taken"}, {15'b0, bus.pc_taken}, {15'b0, e.tk});
            end
        end
    endtask

    task automatic issue(input string tag, input logic [3:0] op,
                         input logic [15:0] r1, input logic [15:0] r2,
                         input logic [15:0] im, input logic [15:0] pc,
                         input logic [1:0] cb, input logic [1:0] fa,
                         input logic [1:0] fb, input logic [1:0] fw,
                         input logic be, input logic [1:0] jb, input logic push,
                         input logic [15:0] e_res, input logic [15:0] e_wd,
                         input logic [15:0] e_npc, input logic e_tk);
        exp_t e;
        bus.alu_op    = op;
        bus.rdata1    = r1;
        bus.rdata2    = r2;
        bus.imme      = im;
        bus.pc_src    = pc;
        bus.control_b = cb;
        bus.fwd_a     = fa;
        bus.fwd_b     = fb;
        bus.fwd_w     = fw;
        bus.branch_en = be;
        bus.jorb      = jb;
        bus.in_valid  = 1'b1;
        if (push) begin
            e.tag = tag; e.res = e_res; e.wd = e_wd; e.npc = e_npc; e.tk = e_tk;
            sb.push_back(e);
        end
        cyc();
        bus.in_valid  = 1'b0;
        bus.branch_en = 1'b0;
    endtask

    // Wait for an iterative result. The bench requires it exactly exp_edges edges after acceptance, with busy high until then.
    task automatic wait_out(input string tag, input int exp_edges, input logic pulse);
        logic got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (pulse && k == 3) begin
                bus.alu_op   = 4'h0;
                bus.in_valid = 1'b1;
            end
            if (k == 7) bus.in_valid = 1'b0;
            cyc();
            if (saw_out) begin
                chk({tag, "_latency"}, 16'(k), 16'(exp_edges));
                chk({tag, "_busy_done"}, {15'b0, bus.busy}, 16'd0);
                got = 1'b1;
                break;
            end else if (k < exp_edges) begin
                chk({tag, "_busy_run"}, {15'b0, bus.busy}, 16'd1);
            end
        end
        bus.in_valid = 1'b0;
        chk({tag, "_seen"}, {15'b0, got}, 16'd1);
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.stall_in = 1'b0; bus.flush = 1'b0;
        bus.rdata1 = '0; bus.rdata2 = '0; bus.imme = '0; bus.pc_src = '0;
        bus.alu_op = '0; bus.control_b = '0; bus.fwd_a = '0; bus.fwd_b = '0; bus.fwd_w = '0;
        bus.alu_back = 16'h0010; bus.wb_data = 16'h0003;
        bus.branch_en = 1'b0; bus.jorb = '0;

        #22;
        chk("rst_out_valid", {15'b0, bus.out_valid}, 16'd0);
        chk("rst_pc_taken", {15'b0, bus.pc_taken}, 16'd0);
        chk("rst_busy", {15'b0, bus.busy}, 16'd0);
        chk("rst_alu_res", bus.alu_res, 16'h0000);
        chk("rst_wdata", bus.wdata, 16'h0000);
        chk("rst_new_pc", bus.new_pc, 16'h0000);
        rst = 1'b1;

        // Single-cycle ALU operations issued back to back. Arguments: tag, op, r1, r2, imme, pc, cb, fa, fb, fw, be, jorb, push, res, wd, npc, taken.
        issue("add",     4'h0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h8000, 16'h0001, 16'h0010, 1'b0);
        chk("add_busy", {15'b0, bus.busy}, 16'd0);
        issue("slt_fwd", 4'h9, 16'hFFF0, 16'h1111, 16'hFFFF, 16'h0011, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h0000, 16'h1111, 16'h0011, 1'b0);
        issue("slt_neg", 4'h9, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h0001, 16'h0001, 16'h0000, 1'b0);
        issue("sra",     4'h8, 16'h8000, 16'h0000, 16'h0003, 16'h0000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'hF000, 16'h0000, 16'h0000, 1'b0);
        issue("srl",     4'h7, 16'h8000, 16'h0000, 16'h0003, 16'h0000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h1000, 16'h0000, 16'h0000, 1'b0);
        issue("sll_wrap",4'h6, 16'h0123, 16'h0000, 16'h0014, 16'h0000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h1230, 16'h0000, 16'h0000, 1'b0);
        issue("sub",     4'h1, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'hFFFE, 16'h0007, 16'h0000, 1'b0);
        issue("and",     4'h2, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'hF000, 16'hFF00, 16'h0000, 1'b0);
        issue("or",      4'h3, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'hFFF0, 16'hFF00, 16'h0000, 1'b0);
        issue("neg",     4'h4, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        issue("not",     4'h5, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'hFF00, 16'h0000, 16'h0000, 1'b0);
        issue("sne_eq",  4'hA, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h0000, 16'h0005, 16'h0000, 1'b0);
        issue("sne_ne",  4'hA, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h0001, 16'h0006, 16'h0000, 1'b0);
        issue("pc_op",   4'hB, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b0);
        issue("zero_op", 4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
        issue("fwd_b_wb",4'h0, 16'h0001, 16'h9999, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 16'h0004, 16'h9999, 16'h0000, 1'b0);
        issue("fwd_w_ex",4'h0, 16'h0001, 16'h9999, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 16'h999A, 16'h0010, 16'h0000, 1'b0);
        issue("fwd_a_0", 4'h0, 16'h0005, 16'h0002, 16'h0000, 16'h0000, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 2'b00, 1'b1, 16'h0002, 16'h0000, 16'h0000, 1'b0);
        issue("cb_zero", 4'h0, 16'h0005, 16'h0009, 16'h0007, 16'h0000, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h0005, 16'h0009, 16'h0000, 1'b0);
        cyc();
        chk("idle_out_valid", {15'b0, bus.out_valid}, 16'd0);

        // Branch and jump resolution
        issue("bnez_tk", 4'h0, 16'h0003, 16'h0000, 16'hFFFE, 16'h0041, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 1'b1, 16'h0001, 16'h0000, 16'h003F, 1'b1);
        issue("beqz_nt", 4'h0, 16'h0003, 16'h0000, 16'hFFFE, 16'h0041, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 16'h0001, 16'h0000, 16'h0041, 1'b0);
        issue("beqz_tk", 4'h0, 16'h0000, 16'h0000, 16'hFFFE, 16'h0041, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 16'hFFFE, 16'h0000, 16'h003F, 1'b1);
        issue("jr",      4'h0, 16'h0003, 16'h0000, 16'hFFFE, 16'h0041, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 16'h0001, 16'h0000, 16'h0003, 1'b1);
        issue("b_uncond",4'h0, 16'h0003, 16'h0000, 16'hFFFE, 16'h0041, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 16'h0001, 16'h0000, 16'h003F, 1'b1);
        cyc();
        chk("idle_pc_taken", {15'b0, bus.pc_taken}, 16'd0);

        // Iterative unit. MUL also pulses in_valid while busy; that pulse must be ignored.
        issue("mul",     4'hC, 16'h0123, 16'h0010, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h1230, 16'h0010, 16'h0000, 1'b0);
        chk("mul_accept_busy", {15'b0, bus.busy}, 16'd1);
        chk("mul_accept_ov", {15'b0, bus.out_valid}, 16'd0);
        wait_out("mul", 17, 1'b1);
        issue("divu",    4'hD, 16'h0064, 16'h0007, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h000E, 16'h0007, 16'h0000, 1'b0);
        wait_out("divu", 17, 1'b0);
        issue("remu",    4'hE, 16'h0064, 16'h0007, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h0002, 16'h0007, 16'h0000, 1'b0);
        wait_out("remu", 17, 1'b0);
        issue("divu_z",  4'hD, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        wait_out("divu_z", 17, 1'b0);
        issue("remu_z",  4'hE, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h0005, 16'h0000, 16'h0000, 1'b0);
        wait_out("remu_z", 17, 1'b0);

        // Stall across completion. The result must park until stall_in is released.
        issue("divu_st", 4'hD, 16'h0064, 16'h0007, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h000E, 16'h0007, 16'h0000, 1'b0);
        cyc(); cyc(); cyc();
        bus.stall_in = 1'b1;
        for (int k = 0; k < 25; k++) begin
            cyc();
            chk("stall_hold_ov", {15'b0, bus.out_valid}, 16'd0);
        end
        chk("stall_busy", {15'b0, bus.busy}, 16'd1);
        bus.stall_in = 1'b0;
        cyc();
        chk("stall_release_ov", {15'b0, saw_out}, 16'd1);
        chk("stall_release_busy", {15'b0, bus.busy}, 16'd0);

        // Flush mid-RUN aborts the operation. No result is queued for it.
        issue("divu_fl", 4'hD, 16'h0064, 16'h0007, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        cyc(); cyc(); cyc();
        chk("flush_pre_busy", {15'b0, bus.busy}, 16'd1);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("flush_busy", {15'b0, bus.busy}, 16'd0);
        chk("flush_ov", {15'b0, bus.out_valid}, 16'd0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("flush_quiet_ov", {15'b0, bus.out_valid}, 16'd0);
        end

        // Reset asserted mid-RUN returns to reset values immediately.
        issue("mul_rst", 4'hC, 16'h0123, 16'h0010, 16'h0000, 16'h0055, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("arst_busy", {15'b0, bus.busy}, 16'd0);
        chk("arst_alu_res", bus.alu_res, 16'h0000);
        chk("arst_wdata", bus.wdata, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) cyc();
        chk("arst_quiet_ov", {15'b0, bus.out_valid}, 16'd0);

        issue("add_post", 4'h0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 16'h3333, 16'h2222, 16'h0000, 1'b0);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
